fixed_point_adder: RTL and testbench

- Registered, saturating two's-complement fixed-point adder for the datapath arithmetic units.
- Adds two 26-bit signed fixed-point operands that share the same Q format.
- Presents the clamped sum on a registered output one clock after the operands are sampled.
- Leaf arithmetic block, instantiated wherever datapath stages accumulate or combine fixed-point values.

---
 rtl/fxp_pkg.sv | 18 +
 rtl/fxp_sat_add.sv | 34 +++
 rtl/fixed_point_adder.sv | 50 +++++
 tb/tb_fixed_point_adder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// ----------------------------------------------------------------------------
// fxp_pkg
//   Shared fixed-point definitions for the datapath arithmetic units.
//   FXP_WIDTH : total word width, sign bit included
//   FXP_FRAC  : fractional bits (binary point is common to all operands)
//   fxp_t     : signed fixed-point word
//   FXP_MAX   : most positive representable value
//   FXP_MIN   : most negative representable value
// ----------------------------------------------------------------------------
package fxp_pkg;
    localparam int FXP_WIDTH = 26;
    localparam int FXP_FRAC  = 16;

    typedef logic signed [FXP_WIDTH-1:0] fxp_t;

    localparam fxp_t FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};
endpackage

// File: rtl/fxp_sat_add.sv
// ----------------------------------------------------------------------------
// fxp_sat_add
//   Combinational two's-complement adder with optional saturation.
//   Ports:
//     a   in  WIDTH  operand A, signed
//     b   in  WIDTH  operand B, signed
//     sum out WIDTH  clamped (SATURATE=1) or wrapped (SATURATE=0) sum
// ----------------------------------------------------------------------------
module fxp_sat_add
    import fxp_pkg::*;
#(
    parameter int WIDTH    = FXP_WIDTH,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] exact;
    logic           ovf;

    // One guard bit makes the sum exact; the guard bit then carries the true sign.
    assign exact = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign ovf   = exact[WIDTH] ^ exact[WIDTH-1];

    always_comb begin
        sum = exact[WIDTH-1:0];
        if (SATURATE && ovf)
            sum = exact[WIDTH] ? SAT_MIN : SAT_MAX;
    end
endmodule

// File: rtl/fixed_point_adder.sv
// ----------------------------------------------------------------------------
// fixed_point_adder
//   Registered saturating fixed-point adder, one cycle latency, one result
//   per clock, no enable or handshake.
//   Ports:
//     clk         in  1      rising-edge clock
//     GlobalReset in  1      asynchronous active-low reset, clears Output_syn
//     Port1       in  WIDTH  operand A, signed
//     Port2       in  WIDTH  operand B, signed
//     Output_syn  out WIDTH  registered sum of the operands sampled last edge
// ----------------------------------------------------------------------------
module fixed_point_adder
    import fxp_pkg::*;
#(
    parameter int WIDTH     = FXP_WIDTH,
    parameter int FRAC_BITS = FXP_FRAC,
    parameter bit SATURATE  = 1'b1
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic [WIDTH-1:0] Port1,
    input  logic [WIDTH-1:0] Port2,
    output logic [WIDTH-1:0] Output_syn
);
    // Binary point is shared by both operands and the result, so FRAC_BITS
    // never enters the arithmetic; it only has to be a sane position.
    generate
        if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_frac
            $error("FRAC_BITS must lie in [0, WIDTH-1]");
        end
    endgenerate

    logic [WIDTH-1:0] sum_nxt;

    fxp_sat_add #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a   (Port1),
        .b   (Port2),
        .sum (sum_nxt)
    );

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset)
            Output_syn <= '0;
        else
            Output_syn <= sum_nxt;
    end
endmodule

// File: tb/tb_fixed_point_adder.sv
// ----------------------------------------------------------------------------
// tb_fixed_point_adder
//   Directed vectors with hand-computed sums; expected values are queued as
//   operands are driven and a monitor compares after each rising edge.
// ----------------------------------------------------------------------------
module tb_fixed_point_adder;
    localparam int W = 26;

    logic         clk = 1'b0;
    logic         GlobalReset;
    logic [W-1:0] Port1;
    logic [W-1:0] Port2;
    logic [W-1:0] Output_syn;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    fixed_point_adder #(
        .WIDTH     (W),
        .FRAC_BITS (16),
        .SATURATE  (1'b1)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .Port1       (Port1),
        .Port2       (Port2),
        .Output_syn  (Output_syn)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%07h expected 0x%07h", nm, got, exp);
        end
    endtask

    // Drive a pair for the next rising edge and queue its expected result.
    task automatic apply(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
        @(negedge clk);
        Port1 = a;
        Port2 = b;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor: each edge out of reset retires one queued expectation.
    initial begin
        logic [W-1:0] e;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (GlobalReset && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, Output_syn, e);
            end
        end
    end

    initial begin
        int waited;
        GlobalReset = 1'b0;
        Port1 = 26'd1234;
        Port2 = 26'd5678;
        #2;
        check("reset_initial", Output_syn, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", Output_syn, '0);
        @(negedge clk);
        GlobalReset = 1'b1;

        apply("zero",        26'd0,       26'd0,       26'd0);
        apply("100+300",     26'd100,     26'd300,     26'd400);
        apply("500+800",     26'd500,     26'd800,     26'd1300);
        apply("1000+2000",   26'd1000,    26'd2000,    26'd3000);
        apply("-100+300",    26'h3FFFF9C, 26'd300,     26'd200);
        apply("-1+-1",       26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFE);
        apply("max+1",       26'h1FFFFFF, 26'd1,       26'h1FFFFFF);
        apply("half+half",   26'h1000000, 26'h1000000, 26'h1FFFFFF);
        apply("max+0",       26'h1FFFFFF, 26'd0,       26'h1FFFFFF);
        apply("min+-1",      26'h2000000, 26'h3FFFFFF, 26'h2000000);
        apply("min+min",     26'h2000000, 26'h2000000, 26'h2000000);
        apply("max+min",     26'h1FFFFFF, 26'h2000000, 26'h3FFFFFF);
        apply("max+-1",      26'h1FFFFFF, 26'h3FFFFFF, 26'h1FFFFFE);
        apply("min+1",       26'h2000000, 26'd1,       26'h2000001);

        // Reset in the middle of a stream: async clear before the next edge.
        apply("pre_reset",   26'd100,     26'd300,     26'd400);
        @(posedge clk);
        #2;
        GlobalReset = 1'b0;
        #1;
        check("reset_async", Output_syn, '0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", Output_syn, '0);
        @(negedge clk);
        GlobalReset = 1'b1;
        apply("7+8_after_reset", 26'd7, 26'd8, 26'd15);
        apply("-2+-3",           26'h3FFFFFE, 26'h3FFFFFD, 26'h3FFFFFB);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
